key_debounce: RTL and testbench
===============================

# key_debounce

Multi-channel push-button conditioner that sits directly upstream of the rising-edge detector in the key-input path. It synchronises raw, asynchronous, bouncing key levels into the `clk` domain and filters them. A new level is passed to `key_out` only after it has been held for a programmable number of consecutive cycles. Downstream edge detection therefore sees exactly one clean transition per physical press or release.

## Interface
- `N_KEYS`, default 5: number of independent key channels.
- `STABLE_CYCLES`, default 2_000_000 (20 ms at 100 MHz): consecutive cycles a new level must persist before it is accepted. Legal values are 2 or more.
- `IDLE_LEVEL`, default 1'b0: released-key level, and the reset value of every `key_out` bit.

- `clk`, input, 1 bit: system clock. All logic runs on its rising edge.
- `rst_n`, input, 1 bit: one clock; reset is asynchronous and active-low.
- `key_in`, input, N_KEYS bits: raw key levels, asynchronous to `clk`, may bounce.
- `key_out`, output, N_KEYS bits: debounced, registered key levels, glitch-free.

## Operation
- **Per-channel pipeline:** 2-FF synchroniser, then a counter and a 2-state FSM. Channels share no state.
  - `s` denotes synchroniser stage-2 output.
  - `cnt` is `$clog2(STABLE_CYCLES)` bits wide.
- **FSM states:**
  - STABLE: `s == key_out`, `cnt == 0`.
  - CONFIRM: `s != key_out`, counting.
- **STABLE → CONFIRM:** when `s != key_out` at a clock edge. At that edge `cnt` becomes 1.
- **CONFIRM, `s == key_out` (bounce back):** go to STABLE and set `cnt` to 0. `key_out` is unchanged.
- **CONFIRM, `s != key_out`, `cnt < STABLE_CYCLES-1`:** `cnt` increments.
- **CONFIRM, `s != key_out`, `cnt == STABLE_CYCLES-1`:** `key_out <= s`, `cnt <= 0`, go to STABLE.
- **Counter range:** `cnt` never exceeds STABLE_CYCLES-1, so no wrap or saturation logic is required.
- **Symmetry:** press and release are filtered identically.
- **Reset (`rst_n` low, any time, including mid-count):** all of the following take effect immediately, without waiting for a clock edge.
  - Both synchroniser stages of every channel = IDLE_LEVEL.
  - `key_out` = {N_KEYS{IDLE_LEVEL}}.
  - `cnt` = 0.
  - FSM = STABLE.
- **After reset release:** a key already held at its non-idle level is qualified from scratch.
- **Outputs:** `key_out` is driven directly from a flop, with no combinational path from `key_in`.

## Timing
- **Synchroniser latency:** a `key_in` change sampled at edge E0 appears on `s` at edge E0+1.
- **Qualification:** let E1 be the first edge at which `s != key_out`. If `s` holds its new value at edges E1 through E1+STABLE_CYCLES-1, `key_out` changes at edge E1+STABLE_CYCLES-1.
  - Total latency from sampling edge to `key_out` change is STABLE_CYCLES+1 cycles.
- **Re-arm:** any single-cycle reversion of `s` during CONFIRM restarts the count. The next qualification window begins at the next edge where `s != key_out`.
- **Minimum output pulse:** `key_out` holds each value for at least STABLE_CYCLES cycles. It therefore cannot toggle faster than that.
- **Metastability:** only the stage-1 synchroniser flop may go metastable. No other logic reads it.
- **Simultaneous events:** any number of channels may change on the same edge, each following its own timing.

## Test plan
All scenarios use N_KEYS=2, STABLE_CYCLES=8, IDLE_LEVEL=0.
- **Reset:** `rst_n=0`, `key_in=2'b11` → `key_out=2'b00` throughout reset. Release `rst_n` and hold `key_in=2'b11` → both `key_out` bits rise exactly 9 cycles after the first post-reset sampling edge.
- **Bouncing press:** toggle `key_in[0]` every 3 cycles for 30 cycles, then hold 1 → `key_out[0]` stays 0 during the bounce. It rises 9 cycles after the last toggle is sampled. `key_out[1]` is unaffected.
- **Glitch rejection:** with `key_out[0]=0`, pulse `key_in[0]` high for 1 cycle, then for 7 cycles → `key_out[0]` never changes. A subsequent 8-cycle high pulse is accepted.
- **Release:** from `key_out[0]=1`, drop `key_in[0]` to 0 and hold → `key_out[0]` falls 9 cycles later. A release with bounce behaves as in the bouncing-press case.
- **Independent channels:** `key_in[0]` rises at cycle 0, `key_in[1]` rises at cycle 3 → `key_out[0]` rises at cycle 9 and `key_out[1]` at cycle 12. Both may also change on the same edge when stimulated together.
- **Reset mid-count:** assert `rst_n` low during CONFIRM with `cnt=5` → `key_out` holds 0 and `cnt` reads 0 immediately. After release, with `key_in` still high → full 9-cycle qualification before `key_out` rises.

Source files
------------

// File: rtl/key_debounce.sv
// Multi-channel key debouncer: 2-FF synchroniser per key, then a stability counter that only
// passes a new level once it has persisted for STABLE_CYCLES consecutive cycles.
module key_debounce #(
  parameter int unsigned N_KEYS        = 5,
  parameter int unsigned STABLE_CYCLES = 2_000_000,
  parameter logic        IDLE_LEVEL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out
);

  localparam int unsigned CntWidth = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(STABLE_CYCLES - 1);

  typedef enum logic {StStable, StConfirm} state_e;

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_chan
    logic                sync1_q;
    logic                sync2_q;
    logic                out_q, out_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    state_e              state_q, state_d;

    // sync1_q may go metastable; only sync2_q reads it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= IDLE_LEVEL;
        sync2_q <= IDLE_LEVEL;
      end else begin
        sync1_q <= key_in[g];
        sync2_q <= sync1_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StStable;
        cnt_q   <= '0;
        out_q   <= IDLE_LEVEL;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      unique case (state_q)
        StStable: begin
          if (sync2_q != out_q) begin
            state_d = StConfirm;
            cnt_d   = CntWidth'(1);
          end
        end
        StConfirm: begin
          if (sync2_q == out_q) begin
            // Bounced back before qualifying: restart from scratch.
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            out_d   = sync2_q;
            cnt_d   = '0;
            state_d = StStable;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
        default: begin
          state_d = StStable;
          cnt_d   = '0;
        end
      endcase
    end

    assign key_out[g] = out_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (2 keys, 8-cycle qualification) using a
// window-based reference model and an expected-value queue.
module tb_key_debounce;

  localparam int unsigned NKeys  = 2;
  localparam int unsigned Stable = 8;
  localparam int unsigned HistSz = Stable + 2;

  logic             clk;
  logic             rst_n;
  logic [NKeys-1:0] key_in;
  logic [NKeys-1:0] key_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [NKeys-1:0] hist[$];
  logic [NKeys-1:0] exp_q[$];
  logic [NKeys-1:0] exp_out;

  key_debounce #(
    .N_KEYS       (NKeys),
    .STABLE_CYCLES(Stable),
    .IDLE_LEVEL   (1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .key_out(key_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [NKeys-1:0] obs,
                          input logic [NKeys-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: key_out=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(HistSz); i++) hist.push_back('0);
    exp_out = '0;
  endtask

  // Output flips at edge k iff the samples taken at edges k-9..k-2 all differ from it.
  task automatic step(input string tag, input logic [NKeys-1:0] v);
    logic [NKeys-1:0] h;
    logic             all_diff;
    key_in = v;
    hist.push_back(v);
    void'(hist.pop_front());
    for (int b = 0; b < int'(NKeys); b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < int'(Stable); i++) begin
        h = hist[i];
        if (h[b] == exp_out[b]) all_diff = 1'b0;
      end
      if (all_diff) exp_out[b] = ~exp_out[b];
    end
    exp_q.push_back(exp_out);
    @(posedge clk);
    #1;
    check_eq(tag, key_out, exp_q.pop_front());
  endtask

  task automatic hold(input string tag, input logic [NKeys-1:0] v, input int n);
    for (int i = 0; i < n; i++) step(tag, v);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases away from the edge.
  task automatic do_reset(input string tag, input logic [NKeys-1:0] v, input int n);
    #2;
    key_in = v;
    rst_n  = 1'b0;
    #1;
    check_eq({tag, "_async"}, key_out, '0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_held"}, key_out, '0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = 2'b11;
    model_reset();
    #1;
    check_eq("reset_async", key_out, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset_held", key_out, 2'b00);
    end
    rst_n = 1'b1;
    hold("reset_release_qual", 2'b11, 12);
    hold("release_both", 2'b00, 12);

    // Bouncing press on key 0.
    for (int i = 0; i < 30; i++) step("bounce_press", ((i / 3) % 2 == 0) ? 2'b01 : 2'b00);
    hold("bounce_press_settle", 2'b01, 12);

    // Release, then a bouncing release.
    hold("release", 2'b00, 12);
    hold("repress", 2'b01, 12);
    for (int i = 0; i < 30; i++) step("bounce_release", ((i / 3) % 2 == 0) ? 2'b00 : 2'b01);
    hold("bounce_release_settle", 2'b00, 12);

    // Glitch rejection: 1-cycle and 7-cycle pulses rejected, 8-cycle accepted.
    hold("glitch_1", 2'b01, 1);
    hold("glitch_gap", 2'b00, 10);
    hold("glitch_7", 2'b01, 7);
    hold("glitch_gap", 2'b00, 10);
    hold("pulse_8", 2'b01, 8);
    hold("pulse_8_after", 2'b00, 4);
    hold("pulse_8_fall", 2'b00, 10);

    // Independent channels: key 0 at cycle 0, key 1 at cycle 3, then together.
    hold("indep_k0", 2'b01, 3);
    hold("indep_k1", 2'b11, 14);
    hold("indep_both_fall", 2'b00, 12);
    hold("indep_both_rise", 2'b11, 12);
    hold("indep_split", 2'b10, 12);
    hold("indep_clear", 2'b00, 12);

    // Reset in the middle of a count.
    hold("midcount_start", 2'b01, 7);
    do_reset("midcount_reset", 2'b01, 3);
    hold("midcount_requal", 2'b01, 12);
    hold("midcount_release", 2'b00, 12);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
